// File: rtl/hs_rx_capture.sv
// Receive-side capture for the clk_a -> clk_b request/acknowledge handshake.
// Synchronizes req_in, captures one word per request into a FIFO, and returns ack_out.
module hs_rx_capture #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk_b,
    input  logic                            rst,
    input  logic                            req_in,
    input  logic [DATA_W-1:0]               data_in,
    output logic                            ack_out,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [7:0]                      drop_cnt,
    output logic                            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_p;
    logic                    req_s;
    logic [DATA_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    rd_fire;
    logic                    has_space;
    logic                    wr_en;
    logic                    drop;

    // Synchronizer: req_in is only ever sampled by the first flop of this chain
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_p[SYNC_STAGES-1];

    // A read on the same edge frees the slot the capture needs
    assign rd_valid  = (fifo_count != '0);
    assign rd_fire   = rd_valid & rd_ready;
    assign has_space = (fifo_count < DEPTH_C) || rd_fire;
    assign wr_en     = (state == CAPTURE) && has_space;
    assign drop      = (state == CAPTURE) && !has_space;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_out <= 1'b0;
                    if (req_s) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state   <= ACK;
                    ack_out <= 1'b1;
                end
                ACK: begin
                    if (!req_s) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_fire})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= sat_inc8(drop_cnt);
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_rx_capture.sv
// Scoreboard bench for hs_rx_capture: handshake driver pushes expected words,
// a negedge monitor pops and compares whatever the DUT hands to the consumer.
module tb_hs_rx_capture;

    localparam int DATA_W      = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic              clk_b = 1'b0;
    logic              rst;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [7:0]        drop_cnt;
    logic              overflow;

    hs_rx_capture #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_b(clk_b), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .fifo_count(fifo_count), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    always #5 clk_b = ~clk_b;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                m_drop  = 0;
    bit                m_ovf   = 1'b0;
    bit                rand_rdy = 1'b0;
    logic [DATA_W-1:0] mon_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Inputs change 1 time unit after the active edge
    task automatic tick();
        @(posedge clk_b);
        #1;
        if (rand_rdy) rd_ready = 1'($urandom_range(0, 1));
    endtask

    // One full request/acknowledge cycle; store says whether the word should land in the FIFO
    task automatic hs(input logic [DATA_W-1:0] d, input int hold, input bit store, input bit rdy_on_cap);
        int n;
        if (store) exp_q.push_back(d);
        else begin
            if (m_drop != 255) m_drop++;
            m_ovf = 1'b1;
        end
        data_in = d;
        req_in  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (rdy_on_cap) rd_ready = (n == SYNC_STAGES + 1);
        end while (!ack_out && n < 20);
        chk("ack_rise_latency", n, SYNC_STAGES + 2);
        if (!rand_rdy && !rd_ready) chk("rd_valid_with_ack", rd_valid, 1);
        data_in = $urandom;
        repeat (hold) begin
            tick();
            chk("ack_held", ack_out, 1);
        end
        req_in = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack_out && n < 20);
        chk("ack_fall_latency", n, SYNC_STAGES + 1);
    endtask

    task automatic pop_all();
        int n;
        rd_ready = 1'b1;
        n = 0;
        while (rd_valid && n < 50) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk("drained_rd_valid", rd_valid, 0);
        chk("drained_count", fifo_count, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
        chk({tag, "_overflow"}, overflow, m_ovf);
    endtask

    // Consumer-side monitor: a pop happens on the next edge when valid & ready
    always @(negedge clk_b) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %08h, no word expected", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", rd_data, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int                h;
        int                n;

        rst = 1'b1; req_in = 1'b0; data_in = '0; rd_ready = 1'b0;
        #3;
        chk("rst_ack_out", ack_out, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_data", rd_data, 0);
        repeat (3) @(posedge clk_b);
        #1 rst = 1'b0;
        tick();

        // Single request
        hs(32'hDEADBEEF, 2, 1'b1, 1'b0);
        chk("single_count", fifo_count, 1);
        chk("single_rd_data", rd_data, 32'hDEADBEEF);
        pop_all();

        // Long request: one capture only
        hs(32'h1234_5678, 20, 1'b1, 1'b0);
        chk("long_count", fifo_count, 1);
        pop_all();

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            hs(DATA_W'(i), 1, (i <= FIFO_DEPTH), 1'b0);
            chk("fill_count", fifo_count, exp_q.size());
        end
        chk("full_count", fifo_count, FIFO_DEPTH);
        chk_status("fill");
        pop_all();

        // Full FIFO with a read on the capture edge: new word must be kept
        for (int i = 0; i < FIFO_DEPTH; i++) hs(32'h11 + DATA_W'(i), 0, 1'b1, 1'b0);
        chk("refill_count", fifo_count, FIFO_DEPTH);
        hs(32'h55, 0, 1'b1, 1'b1);
        chk("simul_rw_count", fifo_count, FIFO_DEPTH);
        chk_status("simul_rw");
        pop_all();

        // Wrap-around with the consumer always ready
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) hs(32'hA0 + DATA_W'(i), 0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("wrap_count", fifo_count, 0);
        chk("wrap_scoreboard_empty", exp_q.size(), 0);
        chk_status("wrap");
        rd_ready = 1'b0;

        // Randomized traffic with a random consumer
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            h = $urandom_range(0, 5);
            if (exp_q.size() < FIFO_DEPTH) begin
                hs(d, h, 1'b1, 1'b0);
            end else begin
                rand_rdy = 1'b0;
                rd_ready = 1'b0;
                hs(d, h, 1'b0, 1'b0);
                rand_rdy = 1'b1;
            end
        end
        rand_rdy = 1'b0;
        pop_all();
        chk_status("random");

        // Reset while in ACK with two words stored
        hs(32'hC0FFEE01, 0, 1'b1, 1'b0);
        exp_q.push_back(32'hC0FFEE02);
        data_in = 32'hC0FFEE02;
        req_in  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack_out && n < 20);
        chk("midack_ack_high", ack_out, 1);
        chk("midack_count", fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        chk("midrst_ack_out", ack_out, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        chk("midrst_overflow", overflow, 0);
        req_in = 1'b0;
        repeat (2) @(posedge clk_b);
        #1 rst = 1'b0;
        tick();
        hs(32'hBEEF0001, 1, 1'b1, 1'b0);
        chk("post_rst_count", fifo_count, 1);
        chk("post_rst_rd_data", rd_data, 32'hBEEF0001);
        pop_all();
        chk_status("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_rx_capture.md
# hs_rx_capture

Receive-side capture stage for the clk_a→clk_b handshake path. It takes the raw request level and the 32-bit word launched from the clk_a domain, synchronizes the request into clk_b, and captures exactly one word per request into a small FIFO. It returns an acknowledge level for the clk_a side to synchronize, and presents captured words to the clk_b consumer through a valid/ready port.

## Interface
- DATA_W, 32, data word width.
- FIFO_DEPTH, 4, capture FIFO entries; must be a power of 2 and ≥2.
- SYNC_STAGES, 2, flops in the req_in synchronizer; must be ≥2.
- clk_b  input  1  capture/consumer clock.
- rst  input  1  reset; rst is asynchronous and active-high, and the block is clocked by clk_b.
- req_in  input  1  raw request level from the clk_a domain. Asynchronous to clk_b.
- data_in  input  DATA_W  word from the clk_a domain. Sender guarantees it is stable from req_in rise until ack_out is seen high.
- ack_out  output  1  registered acknowledge level, returned to the clk_a domain.
- rd_data  output  DATA_W  FIFO head word. Valid only when rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  consumer accepts the head word on this edge when rd_valid=1.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- drop_cnt  output  8  number of requests dropped because the FIFO was full. Saturates at 255.
- overflow  output  1  sticky; set on the first drop and cleared only by rst.

## Operation
- Synchronizer: req_in passes through SYNC_STAGES flops. The last stage is req_s. No other logic samples req_in.
- FSM states: IDLE, CAPTURE, ACK.
  - IDLE (ack_out=0): if req_s=1, go to CAPTURE.
  - CAPTURE (ack_out=0, one cycle): write data_in into the FIFO if space is available, otherwise record a drop. Always go to ACK.
  - ACK (ack_out=1): stay while req_s=1. Go to IDLE when req_s=0.
- Capture count: exactly one capture per req_in high period, however long the period lasts. If req_in is already high when rst releases, that counts as one request.
- FIFO space: a write has space when fifo_count<FIFO_DEPTH, or when a read (rd_valid & rd_ready) occurs on the same edge. A simultaneous read and write leaves fifo_count unchanged.
- Drop on full: the word is discarded, drop_cnt increments (saturating at 255), and overflow is set. The handshake still completes, with ack_out rising as normal.
- Read: rd_data is the combinational read of the head entry. The read pointer advances on rd_valid & rd_ready. rd_ready while empty has no effect.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, synchronizer flops=0, ack_out=0, rd_valid=0, fifo_count=0, pointers=0, storage=0 (so rd_data=0), drop_cnt=0, overflow=0.
- Edge numbering: E0 is the first clk_b edge that samples req_in=1.
  - req_s=1 after edge E(SYNC_STAGES-1).
  - State becomes CAPTURE after E(SYNC_STAGES).
  - After E(SYNC_STAGES+1), the word is written, rd_valid=1 (if the FIFO was empty), fifo_count is incremented, and ack_out=1.
  - With the default SYNC_STAGES=2, capture and ack_out rise occur 3 edges after E0.
- ack_out fall: with F0 as the first edge sampling req_in=0 while in ACK, ack_out=0 after edge F(SYNC_STAGES). That is 2 edges for the default.
- Minimum request spacing: req_in low for fewer than SYNC_STAGES clk_b cycles may be missed. The sender must wait for ack_out low before raising req_in again.
- Read latency: head data is visible in the same cycle as rd_valid. Popping on edge N exposes the next entry after N.
- Reset mid-operation: asserting rst during CAPTURE or ACK flushes the FIFO and drops ack_out immediately. No partial write occurs.

## Test plan
- Reset, then a single request: req_in=1 with data_in=0xDEADBEEF, rd_ready=0 → ack_out and rd_valid rise 3 edges after the first sampled high. rd_data=0xDEADBEEF, fifo_count=1. ack_out falls 2 edges after req_in is sampled low.
- Long request: req_in held high for 20 cycles → exactly one capture (fifo_count=1) and ack_out high throughout.
- Fill and overflow: 5 complete handshakes with 0x1..0x5, rd_ready=0, FIFO_DEPTH=4 → fifo_count=4, drop_cnt=1, overflow=1. Popping then yields 0x1, 0x2, 0x3, 0x4, then rd_valid=0.
- Simultaneous read and write at full: FIFO full, rd_ready=1 on the capture edge → the new word is stored, drop_cnt is unchanged, and fifo_count stays at 4.
- Wrap-around: 10 handshakes with data 0xA0..0xA9, rd_ready=1 throughout → 10 words read in order, drop_cnt=0, fifo_count returns to 0.
- Reset mid-ACK: assert rst while ack_out=1 and fifo_count=2 → ack_out, rd_valid, fifo_count and drop_cnt are all 0 immediately. A new request after release captures normally.
